// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : store_unit
//  Purpose  : Formats stores (SB/SH/SW), traps misaligned or illegal ones,
//             buffers legal stores in a FIFO and issues them one at a time
//             over a req/gnt/ack data-memory write port.
//  Revision : 1.0 - initial release
// ============================================================================
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int unsigned        c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [29:0]        r_fifo_addr  [DEPTH];
    logic [31:0]        r_fifo_wdata [DEPTH];
    logic [3:0]         r_fifo_be    [DEPTH];

    logic               r_exc_valid;
    logic [1:0]         r_exc_cause;
    logic [31:0]        r_exc_addr;

    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_illegal;
    logic               w_misaligned;
    logic               w_accept;
    logic               w_push;
    logic               w_exc;
    logic               w_pop;
    logic               w_mem_req;

    // Accept-time formatting and fault classification
    always_comb begin
        w_wdata      = '0;
        w_be         = '0;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (st_funct3)
            3'b000: begin
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << st_addr[1:0];
            end
            3'b001: begin
                w_wdata      = {2{st_data[15:0]}};
                w_be         = 4'b0011 << st_addr[1:0];
                w_misaligned = st_addr[0];
            end
            3'b010: begin
                w_wdata      = st_data;
                w_be         = 4'b1111;
                w_misaligned = |st_addr[1:0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign st_ready = (r_count != c_full);
    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && !w_illegal && !w_misaligned;
    assign w_exc    = w_accept && (w_illegal || w_misaligned);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone qualifies it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= st_addr[31:2];
            r_fifo_wdata[r_wr_ptr] <= w_wdata;
            r_fifo_be[r_wr_ptr]    <= w_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A push seen in IDLE starts the request next cycle, giving one-cycle latency
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_mem_req    = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) || w_push) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                w_mem_req = 1'b1;
                if (mem_gnt) begin
                    w_pop        = 1'b1;
                    w_state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    w_state_next = ((r_count != '0) || w_push) ? REQ : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_req   = w_mem_req;
    assign mem_addr  = w_mem_req ? {r_fifo_addr[r_rd_ptr], 2'b00} : '0;
    assign mem_wdata = w_mem_req ? r_fifo_wdata[r_rd_ptr] : '0;
    assign mem_be    = w_mem_req ? r_fifo_be[r_rd_ptr] : '0;
    assign busy      = (r_count != '0) || (r_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= '0;
            r_exc_addr  <= '0;
        end else begin
            r_exc_valid <= w_exc;
            if (w_exc) begin
                r_exc_cause <= w_illegal ? 2'b10 : 2'b01;
                r_exc_addr  <= st_addr;
            end
        end
    end

    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_addr  = r_exc_addr;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_unit
//  Purpose  : Directed scoreboard bench for store_unit with a req/gnt/ack
//             memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] addr;
    } exc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [2:0]  st_funct3 = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        busy;

    bit gnt_en    = 1'b1;
    bit ack_en    = 1'b1;
    bit ack_force = 1'b0;
    bit hs_neg    = 1'b0;

    int checks   = 0;
    int failures = 0;

    wr_t  exp_q[$];
    exc_t exc_q[$];

    logic [2:0]  t5_f3   [6] = '{3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
    logic [31:0] t5_addr [6] = '{32'h4000, 32'h4005, 32'h4006, 32'h4008, 32'h400A, 32'h400C};
    logic [31:0] t5_data [6] = '{32'h11111111, 32'h22, 32'h3344, 32'h55667788, 32'h99, 32'hAABB};

    store_unit #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_funct3 (st_funct3),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_addr  (exc_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference formatting: queue a memory write or an exception
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        wr_t  w;
        exc_t e;
        if (f3 > 3'd2) begin
            e.cause = 2'b10;
            e.addr  = a;
            exc_q.push_back(e);
        end else if ((f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00)) begin
            e.cause = 2'b01;
            e.addr  = a;
            exc_q.push_back(e);
        end else begin
            w.addr = {a[31:2], 2'b00};
            case (f3)
                3'd0: begin
                    w.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                    w.be    = 4'b0001 << a[1:0];
                end
                3'd1: begin
                    w.wdata = {d[15:0], d[15:0]};
                    w.be    = a[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w.wdata = d;
                    w.be    = 4'b1111;
                end
            endcase
            exp_q.push_back(w);
        end
    endfunction

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        while (!st_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", {31'b0, st_ready}, 32'd1);
        if (st_ready) begin
            model(f3, a, d);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Memory responder: grant follows request, ack one cycle after grant
    always @(posedge clk) begin
        #2;
        mem_ack = (hs_neg && ack_en) || ack_force;
        mem_gnt = gnt_en && mem_req;
    end

    // Output monitor: head of scoreboard must be presented while requesting
    always @(negedge clk) begin
        if (reset_n && mem_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", {31'b0, mem_req}, 32'd0);
            end else begin
                chk("mem_addr", mem_addr, exp_q[0].addr);
                chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                chk("mem_be", {28'b0, mem_be}, {28'b0, exp_q[0].be});
                if (mem_gnt) begin
                    void'(exp_q.pop_front());
                end
            end
        end
        if (reset_n && exc_valid) begin
            if (exc_q.size() == 0) begin
                chk("unexpected_exc", {31'b0, exc_valid}, 32'd0);
            end else begin
                chk("exc_cause", {30'b0, exc_cause}, {30'b0, exc_q[0].cause});
                chk("exc_addr", exc_addr, exc_q[0].addr);
                void'(exc_q.pop_front());
            end
        end
        hs_neg = reset_n && mem_req && mem_gnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // SB with single-cycle grant and ack
        send(3'd0, 32'h1003, 32'h000000AB);
        chk("latency_req", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        chk("busy_wait_ack", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("busy_after_ack", {31'b0, busy}, 32'd0);

        // SH aligned, then misaligned SW
        send(3'd1, 32'h2002, 32'h00001234);
        send(3'd2, 32'h2001, 32'hDEADBEEF);
        wait_idle(20);
        chk("exc_drained_2", exc_q.size(), 32'd0);

        // Illegal funct3
        send(3'b011, 32'h3000, 32'h00000055);
        chk("illegal_busy_0", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_busy_1", {31'b0, busy}, 32'd0);
        chk("exc_drained_3", exc_q.size(), 32'd0);

        // Grant withheld: buffer fills, third store waits
        gnt_en = 1'b0;
        send(3'd2, 32'h5000, 32'hA0A0A0A0);
        send(3'd2, 32'h5004, 32'hB1B1B1B1);
        fork
            send(3'd2, 32'h5008, 32'hC2C2C2C2);
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("ready_full", {31'b0, st_ready}, 32'd0);
                end
                gnt_en = 1'b1;
            end
        join
        wait_idle(40);
        chk("drained_4", exp_q.size(), 32'd0);

        // Back-to-back with ack held high; crosses pointer wrap
        ack_force = 1'b1;
        send(t5_f3[0], t5_addr[0], t5_data[0]);
        send(t5_f3[1], t5_addr[1], t5_data[1]);
        chk("pushpop_ready", {31'b0, st_ready}, 32'd1);
        for (int i = 2; i < 6; i++) begin
            send(t5_f3[i], t5_addr[i], t5_data[i]);
        end
        wait_idle(40);
        ack_force = 1'b0;
        chk("drained_5", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;

        // Reset during WAIT_ACK with a second store buffered
        ack_en = 1'b0;
        send(3'd2, 32'h6000, 32'h12345678);
        send(3'd2, 32'h6004, 32'h9ABCDEF0);
        @(posedge clk);
        #1;
        chk("stuck_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, st_ready}, 32'd1);
        chk("mid_rst_exc_cause", {30'b0, exc_cause}, 32'd0);
        chk("mid_rst_exc_addr", exc_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        ack_en    = 1'b1;
        ack_force = 1'b1;
        @(posedge clk);
        #1;
        ack_force = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("late_ack_req", {31'b0, mem_req}, 32'd0);
            chk("late_ack_busy", {31'b0, busy}, 32'd0);
        end

        chk("final_wr_q", exp_q.size(), 32'd0);
        chk("final_exc_q", exc_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
